// File: rtl/css_pkg.sv
// Shared defaults and the stage-1 record layout for the carry-select subtractor.
// The optional saturating clamp is selected with the CSS_SUB_SAT_EN macro (see css_sub_pipe).
package css_pkg;

    localparam int CSS_WIDTH = 8;
    localparam int CSS_SPLIT = 4;

    // Stage-1 record at the default geometry; the top declares the same layout for its own WIDTH/SPLIT.
    typedef struct packed {
        logic [CSS_SPLIT-1:0]           dlo;
        logic                           bor_lo;
        logic [CSS_WIDTH-CSS_SPLIT-1:0] dhi0;
        logic                           bor_hi0;
        logic [CSS_WIDTH-CSS_SPLIT-1:0] dhi1;
        logic                           bor_hi1;
    } stage1_t;

endpackage

// File: rtl/css_sub_seg.sv
// Combinational W-bit subtract segment: {bout, diff} = a - b - bin.
// bout is the sign bit of the (W+1)-bit result, i.e. set iff a < b + bin.
module css_sub_seg
    import css_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W:0] full;

    always_comb begin
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    end

    assign diff = full[W-1:0];
    assign bout = full[W];

endmodule

// File: rtl/css_sub_pipe.sv
// Two-stage pipelined carry-select subtractor with valid/ready on both sides.
// Define CSS_SUB_SAT_EN to clamp diff to zero whenever a < b (borrow still reported).
module css_sub_pipe
    import css_pkg::*;
#(
    parameter int WIDTH = CSS_WIDTH,
    parameter int SPLIT = CSS_SPLIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int HI = WIDTH - SPLIT;

    if (WIDTH < 2 || SPLIT < 1 || SPLIT > WIDTH - 1) begin : g_bad_params
        $error("css_sub_pipe: illegal WIDTH/SPLIT combination");
    end

    typedef struct packed {
        logic [SPLIT-1:0] dlo;
        logic             bor_lo;
        logic [HI-1:0]    dhi0;
        logic             bor_hi0;
        logic [HI-1:0]    dhi1;
        logic             bor_hi1;
    } s1_t;

    s1_t              s1_q, s1_d, s1_new;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic [SPLIT-1:0] dlo_w;
    logic [HI-1:0]    dhi0_w, dhi1_w;
    logic             bor_lo_w, bor_hi0_w, bor_hi1_w;

    logic             s2_load, s1_adv, in_ready_c, s1_accept;
    logic [HI-1:0]    sel_dhi;
    logic             sel_bor;
    logic [WIDTH-1:0] res_diff;

    // Low segment plus both speculative high segments (borrow-in 0 and 1).
    css_sub_seg #(.W(SPLIT)) u_lo (
        .a(a[SPLIT-1:0]), .b(b[SPLIT-1:0]), .bin(1'b0), .diff(dlo_w), .bout(bor_lo_w)
    );
    css_sub_seg #(.W(HI)) u_hi0 (
        .a(a[WIDTH-1:SPLIT]), .b(b[WIDTH-1:SPLIT]), .bin(1'b0), .diff(dhi0_w), .bout(bor_hi0_w)
    );
    css_sub_seg #(.W(HI)) u_hi1 (
        .a(a[WIDTH-1:SPLIT]), .b(b[WIDTH-1:SPLIT]), .bin(1'b1), .diff(dhi1_w), .bout(bor_hi1_w)
    );

    always_comb begin
        s1_new.dlo     = dlo_w;
        s1_new.bor_lo  = bor_lo_w;
        s1_new.dhi0    = dhi0_w;
        s1_new.bor_hi0 = bor_hi0_w;
        s1_new.dhi1    = dhi1_w;
        s1_new.bor_hi1 = bor_hi1_w;

        sel_dhi  = s1_q.bor_lo ? s1_q.dhi1 : s1_q.dhi0;
        sel_bor  = s1_q.bor_lo ? s1_q.bor_hi1 : s1_q.bor_hi0;
        res_diff = {sel_dhi, s1_q.dlo};
`ifdef CSS_SUB_SAT_EN
        if (sel_bor) begin
            res_diff = '0;
        end
`endif
    end

    // in_ready depends only on registered state and out_ready, never on in_valid.
    always_comb begin
        s2_load    = !s2_valid_q || out_ready;
        s1_adv     = s1_valid_q && s2_load;
        in_ready_c = !s1_valid_q || s1_adv;
        s1_accept  = in_valid && in_ready_c;

        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;

        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s1_accept) begin
            s1_valid_d = 1'b1;
            s1_d       = s1_new;
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d   = res_diff;
                borrow_d = sel_bor;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_css_sub_pipe.sv
// Scoreboard bench for css_sub_pipe: driver pushes expected {borrow,diff}, monitor pops on each output transfer.
// SPLIT=1 and SPLIT=7 instances run in lock-step on the same stimulus and are checked against the same expectations.
module tb_css_sub_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow;

    logic       in_ready_s1, out_valid_s1, borrow_s1;
    logic [7:0] diff_s1;
    logic       in_ready_s7, out_valid_s7, borrow_s7;
    logic [7:0] diff_s7;

    int checks = 0;
    int errors = 0;
    int sent   = 0;
    int recv   = 0;
    bit rnd    = 0;

    logic [8:0] exp_q[$];

    logic       hold_pend = 0;
    logic [7:0] hold_diff;
    logic       hold_bor;

    css_sub_pipe #(.WIDTH(8), .SPLIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow)
    );
    css_sub_pipe #(.WIDTH(8), .SPLIT(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s1), .a(a), .b(b),
        .out_valid(out_valid_s1), .out_ready(out_ready), .diff(diff_s1), .borrow(borrow_s1)
    );
    css_sub_pipe #(.WIDTH(8), .SPLIT(7)) dut_s7 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s7), .a(a), .b(b),
        .out_valid(out_valid_s7), .out_ready(out_ready), .diff(diff_s7), .borrow(borrow_s7)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] sat(input logic [8:0] raw);
        logic [8:0] r;
        r = raw;
`ifdef CSS_SUB_SAT_EN
        if (r[8]) r[7:0] = 8'h00;
`endif
        return r;
    endfunction

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y);
        return sat({1'b0, x} - {1'b0, y});
    endfunction

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, got, want);
        end
    endtask

    // Caller is positioned just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [8:0] expv);
        int tries;
        tries = 0;
        a = av;
        b = bv;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expv);
                sent++;
                @(posedge clk); #1;
                if (rnd) out_ready = ($urandom_range(0, 3) != 0);
                break;
            end
            tries++;
            if (tries > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", tries);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitor: checks every output transfer against the scoreboard and output stability under stall.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                checks++;
                if (!(out_valid === 1'b1 && diff === hold_diff && borrow === hold_bor)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b diff=%02h borrow=%0b expected v=1 diff=%02h borrow=%0b",
                             out_valid, diff, borrow, hold_diff, hold_bor);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got diff=%02h borrow=%0b expected no output", diff, borrow);
                end else begin
                    e = exp_q.pop_front();
                    recv++;
                    $display("xfer %0d: diff=%02h borrow=%0b (exp diff=%02h borrow=%0b)",
                             recv, diff, borrow, e[7:0], e[8]);
                    if ({borrow, diff} !== e) begin
                        errors++;
                        $display("FAIL result: got diff=%02h borrow=%0b expected diff=%02h borrow=%0b",
                                 diff, borrow, e[7:0], e[8]);
                    end
                    checks++;
                    if (!(out_valid_s1 === 1'b1 && {borrow_s1, diff_s1} === e)) begin
                        errors++;
                        $display("FAIL result_split1: got v=%0b diff=%02h borrow=%0b expected diff=%02h borrow=%0b",
                                 out_valid_s1, diff_s1, borrow_s1, e[7:0], e[8]);
                    end
                    checks++;
                    if (!(out_valid_s7 === 1'b1 && {borrow_s7, diff_s7} === e)) begin
                        errors++;
                        $display("FAIL result_split7: got v=%0b diff=%02h borrow=%0b expected diff=%02h borrow=%0b",
                                 out_valid_s7, diff_s7, borrow_s7, e[7:0], e[8]);
                    end
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_diff = diff;
            hold_bor  = borrow;
        end
    end

    // Directed vectors: a, b, hand-computed raw {borrow, diff}.
    logic [7:0] vec_a   [8] = '{8'h35, 8'h30, 8'h05, 8'hAA, 8'h00, 8'hFF, 8'h80, 8'h7F};
    logic [7:0] vec_b   [8] = '{8'h12, 8'h01, 8'h10, 8'hAA, 8'hFF, 8'h00, 8'h7F, 8'h80};
    logic [8:0] vec_exp [8] = '{9'h023, 9'h02F, 9'h1F5, 9'h000, 9'h101, 9'h0FF, 9'h001, 9'h1FF};

    initial begin
        logic [7:0] ra, rb;
        rst = 1'b1;
        in_valid = 1'b0;
        a = 8'h00;
        b = 8'h00;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check1("reset_out_valid", out_valid, 1'b0);
        checks++;
        if (diff !== 8'h00 || borrow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got diff=%02h borrow=%0b expected diff=00 borrow=0", diff, borrow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check1("reset_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Directed vectors back to back, including boundary cases
        for (int i = 0; i < 8; i++) begin
            send(vec_a[i], vec_b[i], sat(vec_exp[i]));
        end
        drain();

        // Backpressure: two ops buffered, third held off for three cycles
        out_ready = 1'b0;
        send(8'h35, 8'h12, sat(9'h023));
        send(8'h30, 8'h01, sat(9'h02F));
        a = 8'h05;
        b = 8'h10;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("bp_in_ready_low", in_ready, 1'b0);
            check1("bp_out_valid", out_valid, 1'b1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(8'h05, 8'h10, sat(9'h1F5));
        send(8'h00, 8'hFF, sat(9'h101));
        drain();

        // Reset with two ops in flight
        out_ready = 1'b0;
        send(8'hAA, 8'h55, sat(9'h055));
        send(8'h11, 8'h22, sat(9'h1EF));
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check1("rst_async_out_valid", out_valid, 1'b0);
        exp_q.delete();
        sent = recv;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check1("rst_release_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("rst_no_stale", out_valid, 1'b0);
        end
        @(posedge clk); #1;

        // Random operands with random input gaps and output stalls
        rnd = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
            ra = 8'($urandom);
            rb = 8'($urandom);
            send(ra, rb, model(ra, rb));
        end
        rnd = 0;
        drain();

        checks++;
        if (recv != sent) begin
            errors++;
            $display("FAIL count: got %0d results expected %0d", recv, sent);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
